// File: rtl/updn_counter_prescaled.sv
// Up/down counter with a clock-enable prescaler, modulo limit MAX, clamped parallel load and
// registered tick / terminal-count pulses. Define UPDN_SATURATE_EN to enable saturate mode.
module updn_counter_prescaled #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned FACTOR_W = 5,
  parameter int unsigned MAX      = 2**WIDTH-1
) (
  input  logic                updn_port_clk,
  input  logic                updn_port_rst,
  input  logic                updn_port_en,
  input  logic [FACTOR_W-1:0] updn_port_clk_factor,
  input  logic                updn_port_clk_rst,
  input  logic                updn_port_dir_sel,
  input  logic                updn_port_load,
  input  logic [WIDTH-1:0]    updn_port_load_val,
  input  logic                updn_port_sat,
  output logic [WIDTH-1:0]    updn_port_count,
  output logic                updn_port_tick,
  output logic                updn_port_tc
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [FACTOR_W-1:0] pre_q, pre_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic                tick_q, tick_d;
  logic                tc_q, tc_d;
  logic                sat_mode;
  logic                at_end;

`ifdef UPDN_SATURATE_EN
  assign sat_mode = updn_port_sat;
`else
  logic unused_sat;
  assign unused_sat = updn_port_sat;
  assign sat_mode   = 1'b0;
`endif

  assign at_end = updn_port_dir_sel ? (count_q == '0) : (count_q == MAX_V);

  // Priority: load, then prescaler clear, then enabled counting.
  always_comb begin
    pre_d   = pre_q;
    count_d = count_q;
    tick_d  = 1'b0;
    tc_d    = 1'b0;
    if (updn_port_load) begin
      count_d = (updn_port_load_val > MAX_V) ? MAX_V : updn_port_load_val;
      pre_d   = '0;
    end else if (updn_port_clk_rst) begin
      pre_d = '0;
    end else if (updn_port_en) begin
      // >= so a factor shrunk below the current phase ticks at once.
      if (pre_q >= updn_port_clk_factor) begin
        pre_d  = '0;
        tick_d = 1'b1;
        if (at_end) begin
          tc_d = 1'b1;
          if (!sat_mode) count_d = updn_port_dir_sel ? MAX_V : '0;
        end else begin
          count_d = updn_port_dir_sel ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
        end
      end else begin
        pre_d = pre_q + FACTOR_W'(1);
      end
    end
  end

  always_ff @(posedge updn_port_clk or negedge updn_port_rst) begin
    if (!updn_port_rst) begin
      pre_q   <= '0;
      count_q <= '0;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
    end
  end

  assign updn_port_count = count_q;
  assign updn_port_tick  = tick_q;
  assign updn_port_tc    = tc_q;

endmodule
